// File: rtl/link_tx_scheduler.sv
// Four-way arbiter and serial framer for the board-to-board TX wire.
// Frame: start 0, 2-bit id, payload, even parity, stop 1, then idle-high gap; LSB first.
module link_tx_scheduler #(
   parameter int BAUD_DIV  = 5208,
   parameter int PAYLOAD_W = 12,
   parameter int GAP_BITS  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 link_en,
   input  logic [3:0]           req,
   input  logic [PAYLOAD_W-1:0] cell_payload,
   output logic [3:0]           ack,
   output logic                 tx,
   output logic                 busy,
   output logic                 frame_done
);

   localparam int CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int DATA_BITS = PAYLOAD_W + 2;
   localparam int BW        = $clog2(DATA_BITS + GAP_BITS + 1);
   localparam int SW        = PAYLOAD_W + 3;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

   state_t                 state, state_n;
   logic [CW-1:0]          cnt, cnt_n;
   logic [BW-1:0]          bits, bits_n;
   logic [SW-1:0]          sh, sh_n;
   logic                   tx_n;
   logic [3:0]             ack_n;
   logic [1:0]             gid;
   logic [PAYLOAD_W-1:0]   gpl;
   logic                   term;

   assign term       = (cnt == CW'(BAUD_DIV - 1));
   assign busy       = (state != IDLE);
   assign frame_done = (state == STOP) && term;

   // Fixed priority: lowest requester index wins.
   always_comb begin
      gid = 2'd3;
      if (req[2]) gid = 2'd2;
      if (req[1]) gid = 2'd1;
      if (req[0]) gid = 2'd0;
   end

   assign gpl = (gid == 2'd3) ? cell_payload : '0;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      bits_n  = bits;
      sh_n    = sh;
      tx_n    = tx;
      ack_n   = '0;
      if (state != IDLE) cnt_n = term ? '0 : cnt + CW'(1);
      case (state)
         IDLE: if (link_en && req != '0) begin
            state_n = START;
            cnt_n   = '0;
            bits_n  = '0;
            sh_n    = {^{gid, gpl}, gpl, gid};
            tx_n    = 1'b0;
            ack_n   = 4'b0001 << gid;
         end
         START: if (term) begin
            state_n = DATA;
            tx_n    = sh[0];
         end
         // tx is registered, so the bit shown next is sh[1] before the shift lands;
         // on the last data bit that is the parity bit.
         DATA: if (term) begin
            sh_n = sh >> 1;
            tx_n = sh[1];
            if (bits == BW'(DATA_BITS - 1)) begin
               state_n = PARITY;
               bits_n  = '0;
            end else begin
               bits_n = bits + BW'(1);
            end
         end
         PARITY: if (term) begin
            state_n = STOP;
            tx_n    = 1'b1;
         end
         STOP: if (term) state_n = GAP;
         GAP: if (term) begin
            if (bits == BW'(GAP_BITS - 1)) begin
               state_n = IDLE;
               bits_n  = '0;
            end else begin
               bits_n = bits + BW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         bits  <= '0;
         sh    <= '0;
         tx    <= 1'b1;
         ack   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         bits  <= bits_n;
         sh    <= sh_n;
         tx    <= tx_n;
         ack   <= ack_n;
      end
   end

endmodule
